// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the MEM-stage load/store unit and the data memory.
// Single outstanding req/ack transaction; read data is valid alongside ack.
interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through, runs one big-endian req/ack bus access per memory op.
// Aligned memory ops take IDLE+BUSY(>=1) stall cycles; stallreq holds upstream until DONE, DONE waits out stall[4].
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_reg_we,
  input  logic [31:0] ex_wdata,
  input  logic        ex_hi_we,
  input  logic        ex_lo_we,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  output logic [4:0]  mem_waddr,
  output logic        mem_reg_we,
  output logic [31:0] mem_data,
  output logic        mem_hi_we,
  output logic        mem_lo_we,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stallreq,
  output logic        mem_misalign,
  mem_lsu_if.master   dbus
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic        is_load, is_store, is_mem, ld_signed, misalign, go;
  size_t       size;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] ld_ext;
  logic [31:0] ldata;

  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Opcode decode
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    ld_signed = 1'b0;
    size      = SZ_W;
    case (ex_aluop)
      EXE_LB_OP:  begin is_load  = 1'b1; size = SZ_B; ld_signed = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; size = SZ_B; end
      EXE_LH_OP:  begin is_load  = 1'b1; size = SZ_H; ld_signed = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; size = SZ_H; end
      EXE_LW_OP:  begin is_load  = 1'b1; size = SZ_W; end
      EXE_SB_OP:  begin is_store = 1'b1; size = SZ_B; end
      EXE_SH_OP:  begin is_store = 1'b1; size = SZ_H; end
      EXE_SW_OP:  begin is_store = 1'b1; size = SZ_W; end
      default:    ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign misalign = is_mem &&
                    (((size == SZ_H) && ex_mem_addr[0]) ||
                     ((size == SZ_W) && (ex_mem_addr[1:0] != 2'b00)));
  assign go       = is_mem && !misalign;

  // Big-endian lane select and store-data replication
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = ex_reg2;
    case (size)
      SZ_B: begin
        sel_nxt   = 4'b1000 >> ex_mem_addr[1:0];
        wdata_nxt = {4{ex_reg2[7:0]}};
      end
      SZ_H: begin
        sel_nxt   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_nxt = {2{ex_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction; EX/MEM is frozen, so the live address picks the lane
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (ex_mem_addr[1:0])
      2'd0:    b = dbus.rdata[31:24];
      2'd1:    b = dbus.rdata[23:16];
      2'd2:    b = dbus.rdata[15:8];
      default: b = dbus.rdata[7:0];
    endcase
    h = ex_mem_addr[1] ? dbus.rdata[15:0] : dbus.rdata[31:16];
    case (size)
      SZ_B:    ld_ext = {{24{ld_signed & b[7]}}, b};
      SZ_H:    ld_ext = {{16{ld_signed & h[15]}}, h};
      default: ld_ext = dbus.rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stallreq     = 1'b0;
    mem_misalign = misalign;
    mem_waddr    = ex_waddr;
    mem_reg_we   = ex_reg_we;
    mem_data     = ex_wdata;
    mem_hi_we    = ex_hi_we;
    mem_lo_we    = ex_lo_we;
    mem_hi       = ex_hi;
    mem_lo       = ex_lo;

    case (state)
      IDLE:    if (go) state_nxt = BUSY;
      BUSY:    if (dbus.ack) state_nxt = DONE;
      DONE:    if (!stall[4]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (is_mem) begin
      if (misalign) begin
        mem_reg_we = 1'b0;
      end else if (state == DONE) begin
        if (is_store) mem_reg_we = 1'b0;
        else          mem_data   = ldata;
      end else begin
        stallreq   = 1'b1;
        mem_reg_we = 1'b0;
      end
    end

    if (rst) begin
      stallreq     = 1'b0;
      mem_misalign = 1'b0;
      mem_waddr    = NOP_REG_ADDR;
      mem_reg_we   = 1'b0;
      mem_data     = 32'h0;
      mem_hi_we    = 1'b0;
      mem_lo_we    = 1'b0;
      mem_hi       = 32'h0;
      mem_lo       = 32'h0;
    end
  end

  // Bus fields are latched on launch and held until the acknowledging edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
      ldata   <= 32'h0;
    end else if (state == IDLE && go) begin
      req_q   <= 1'b1;
      we_q    <= is_store;
      addr_q  <= {ex_mem_addr[31:2], 2'b00};
      sel_q   <= sel_nxt;
      wdata_q <= wdata_nxt;
    end else if (state == BUSY && dbus.ack) begin
      req_q   <= 1'b0;
      ldata   <= ld_ext;
    end
  end

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.sel   = sel_q;
  assign dbus.wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, byte/half/word accesses, wait states, misalignment, reset and back-to-back ops.
module tb_mem_lsu;

  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk, rst;
  logic [5:0]  stall;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr, ex_reg2, ex_wdata, ex_hi, ex_lo;
  logic [4:0]  ex_waddr;
  logic        ex_reg_we, ex_hi_we, ex_lo_we;
  logic [4:0]  mem_waddr;
  logic        mem_reg_we, mem_hi_we, mem_lo_we;
  logic [31:0] mem_data, mem_hi, mem_lo;
  logic        stallreq, mem_misalign;

  mem_lsu_if dbus ();

  mem_lsu dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_wdata(ex_wdata),
    .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we), .mem_data(mem_data),
    .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .stallreq(stallreq), .mem_misalign(mem_misalign),
    .dbus(dbus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Acts as memory: acks in the busy_n-th BUSY cycle and records what the DUT drove.
  task automatic run_op(input int busy_n, input logic [31:0] rdata, output int stalls,
                        output logic [3:0] sel_o, output logic we_o,
                        output logic [31:0] addr_o, output logic [31:0] wdata_o,
                        output logic held);
    int busy;
    int guard;
    stalls = 0; busy = 0; guard = 0; held = 1'b1;
    sel_o = 4'h0; we_o = 1'b0; addr_o = 32'h0; wdata_o = 32'h0;
    while (stallreq === 1'b1 && guard < 40) begin
      stalls++;
      guard++;
      if (dbus.req === 1'b1) begin
        busy++;
        if (busy == 1) begin
          sel_o = dbus.sel; we_o = dbus.we; addr_o = dbus.addr; wdata_o = dbus.wdata;
        end else if (dbus.sel !== sel_o || dbus.we !== we_o ||
                     dbus.addr !== addr_o || dbus.wdata !== wdata_o) begin
          held = 1'b0;
        end
        if (busy >= busy_n) begin
          dbus.ack = 1'b1;
          dbus.rdata = rdata;
        end
      end
      tick();
      dbus.ack = 1'b0;
      dbus.rdata = 32'h0;
    end
  endtask

  int          s1, s2;
  logic [3:0]  sel_o;
  logic        we_o, held, saw_req;
  logic [31:0] addr_o, wdata_o;

  initial begin
    rst = 1'b1; stall = 6'b0;
    ex_aluop = OP_LW; ex_mem_addr = 32'h40; ex_reg2 = 32'h0;
    ex_waddr = 5'd7; ex_reg_we = 1'b1; ex_wdata = 32'hDEADBEEF;
    ex_hi_we = 1'b1; ex_lo_we = 1'b1; ex_hi = 32'h1111; ex_lo = 32'h2222;
    dbus.ack = 1'b0; dbus.rdata = 32'h0;

    #2;
    check("rst_req", dbus.req, 1'b0);
    check("rst_stallreq", stallreq, 1'b0);
    check("rst_waddr", mem_waddr, 5'd0);
    check("rst_reg_we", mem_reg_we, 1'b0);
    check("rst_data", mem_data, 32'h0);
    check("rst_hi", mem_hi, 32'h0);
    check("rst_hi_we", mem_hi_we, 1'b0);
    check("rst_sel", dbus.sel, 4'h0);
    tick(); tick();

    // Pass-through
    rst = 1'b0;
    ex_aluop = OP_ADD; ex_wdata = 32'h12345678; ex_waddr = 5'd3; ex_reg_we = 1'b1;
    ex_hi_we = 1'b1; ex_hi = 32'hAAAA0000; ex_lo_we = 1'b0; ex_lo = 32'h5555;
    #1;
    check("pt_data", mem_data, 32'h12345678);
    check("pt_reg_we", mem_reg_we, 1'b1);
    check("pt_waddr", mem_waddr, 5'd3);
    check("pt_stallreq", stallreq, 1'b0);
    check("pt_hi", mem_hi, 32'hAAAA0000);
    check("pt_hi_we", mem_hi_we, 1'b1);
    check("pt_lo", mem_lo, 32'h5555);
    check("pt_lo_we", mem_lo_we, 1'b0);
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dbus.req !== 1'b0) saw_req = 1'b1;
    end
    check("pt_no_req", saw_req, 1'b0);

    // LB zero-wait at 0x1001
    ex_hi_we = 1'b0; ex_hi = 32'h0;
    ex_aluop = OP_LB; ex_mem_addr = 32'h1001; ex_waddr = 5'd5; ex_reg_we = 1'b1; ex_wdata = 32'h1001;
    #1;
    check("lb_idle_reg_we", mem_reg_we, 1'b0);
    run_op(1, 32'h00F30000, s1, sel_o, we_o, addr_o, wdata_o, held);
    check("lb_stalls", s1, 2);
    check("lb_sel", sel_o, 4'b0100);
    check("lb_we", we_o, 1'b0);
    check("lb_addr", addr_o, 32'h1000);
    check("lb_data", mem_data, 32'hFFFFFFF3);
    check("lb_reg_we", mem_reg_we, 1'b1);
    check("lb_req_clear", dbus.req, 1'b0);
    tick();

    // LBU, then hold DONE under stall[4]
    ex_aluop = OP_LBU;
    #1;
    run_op(1, 32'h00F30000, s1, sel_o, we_o, addr_o, wdata_o, held);
    check("lbu_stalls", s1, 2);
    check("lbu_data", mem_data, 32'h000000F3);
    stall = 6'b010000;
    tick();
    check("hold_stallreq", stallreq, 1'b0);
    check("hold_data", mem_data, 32'h000000F3);
    stall = 6'b0;
    tick();

    // SH with three BUSY cycles
    ex_aluop = OP_SH; ex_mem_addr = 32'h2002; ex_reg2 = 32'hABCD1234; ex_reg_we = 1'b1;
    #1;
    run_op(3, 32'h0, s1, sel_o, we_o, addr_o, wdata_o, held);
    check("sh_stalls", s1, 4);
    check("sh_we", we_o, 1'b1);
    check("sh_sel", sel_o, 4'b0011);
    check("sh_wdata", wdata_o, 32'h12341234);
    check("sh_addr", addr_o, 32'h2000);
    check("sh_held", held, 1'b1);
    check("sh_reg_we", mem_reg_we, 1'b0);
    tick();

    // Misaligned LW
    ex_aluop = OP_LW; ex_mem_addr = 32'h3; ex_reg_we = 1'b1;
    #1;
    check("mis_flag", mem_misalign, 1'b1);
    check("mis_stallreq", stallreq, 1'b0);
    check("mis_reg_we", mem_reg_we, 1'b0);
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dbus.req !== 1'b0) saw_req = 1'b1;
    end
    check("mis_no_req", saw_req, 1'b0);

    // Reset during BUSY
    ex_mem_addr = 32'h20;
    #1;
    check("rstmid_idle_stall", stallreq, 1'b1);
    tick();
    check("rstmid_busy_req", dbus.req, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid_req", dbus.req, 1'b0);
    check("rstmid_stallreq", stallreq, 1'b0);
    check("rstmid_waddr", mem_waddr, 5'd0);
    tick();
    rst = 1'b0;
    ex_aluop = OP_ADD; ex_wdata = 32'h77; ex_reg_we = 1'b1;
    dbus.ack = 1'b1; dbus.rdata = 32'hFFFFFFFF;
    tick();
    dbus.ack = 1'b0; dbus.rdata = 32'h0;
    check("late_ack_req", dbus.req, 1'b0);
    check("late_ack_stall", stallreq, 1'b0);
    check("late_ack_data", mem_data, 32'h77);
    ex_aluop = OP_LW; ex_mem_addr = 32'h20;
    #1;
    run_op(1, 32'h13579BDF, s1, sel_o, we_o, addr_o, wdata_o, held);
    check("post_rst_stalls", s1, 2);
    check("post_rst_data", mem_data, 32'h13579BDF);
    tick();

    // Back-to-back LW then SW
    ex_aluop = OP_LW; ex_mem_addr = 32'h10; ex_waddr = 5'd9; ex_reg_we = 1'b1;
    #1;
    run_op(1, 32'hCAFEBABE, s1, sel_o, we_o, addr_o, wdata_o, held);
    check("b2b_lw_addr", addr_o, 32'h10);
    check("b2b_lw_sel", sel_o, 4'b1111);
    check("b2b_lw_data", mem_data, 32'hCAFEBABE);
    check("b2b_lw_reg_we", mem_reg_we, 1'b1);
    tick();
    ex_aluop = OP_SW; ex_mem_addr = 32'h14; ex_reg2 = 32'h55AA55AA; ex_reg_we = 1'b0;
    #1;
    run_op(1, 32'h0, s2, sel_o, we_o, addr_o, wdata_o, held);
    check("b2b_total_stalls", s1 + s2, 4);
    check("b2b_sw_we", we_o, 1'b1);
    check("b2b_sw_addr", addr_o, 32'h14);
    check("b2b_sw_wdata", wdata_o, 32'h55AA55AA);
    check("b2b_sw_reg_we", mem_reg_we, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
